// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: one-outstanding imem handshake, skid slot, redirect, opcode predecode
// Optional IF_MISALIGN_EXC_EN: misaligned redirect reports fetch_misalign instead of fetching.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [31:0] inst_enable,
`ifdef IF_MISALIGN_EXC_EN
    output logic        fetch_misalign,
`endif
    output logic        inst_valid
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    function automatic logic [31:0] predecode(input logic [31:0] w);
        if (w[1:0] == 2'b11) begin
            return ~(32'h0000_0001 << w[6:2]);
        end
        return 32'hFFFF_FFFF;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_en_q, inst_en_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic        accept;
    logic        slot_free;
    logic [31:0] redirect_tgt;
    logic        gate_req;

`ifdef IF_MISALIGN_EXC_EN
    logic misalign_q, misalign_d;
    logic bad_target;
    assign bad_target     = (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt   = redirect_pc;
    assign gate_req       = misalign_q;
    assign fetch_misalign = misalign_q;
`else
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];
    assign redirect_tgt       = {redirect_pc[31:2], 2'b00};
    assign gate_req           = 1'b0;
`endif

    assign imem_req    = (state_q == S_REQ) && !gate_req;
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req && imem_ack;
    assign slot_free   = !valid_q || !stall;

    assign pc          = pc_q;
    assign inst        = inst_q;
    assign inst_enable = inst_en_q;
    assign inst_valid  = valid_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        kill_d      = kill_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_en_d   = inst_en_q;
        valid_d     = valid_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
`ifdef IF_MISALIGN_EXC_EN
        misalign_d  = misalign_q;
`endif

        if (redirect) begin
            // Redirect kills whatever is in flight; the memory response still has to be drained.
            fetch_pc_d = redirect_tgt;
            valid_d    = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    kill_d  = accept;
                    state_d = accept ? S_WAIT : S_REQ;
                end
                S_WAIT: begin
                    kill_d  = !imem_rvalid;
                    state_d = imem_rvalid ? S_REQ : S_WAIT;
                end
                default: begin
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end
            endcase
`ifdef IF_MISALIGN_EXC_EN
            misalign_d = bad_target;
            if (bad_target) begin
                valid_d   = 1'b1;
                pc_d      = redirect_pc;
                inst_d    = NOP;
                inst_en_d = predecode(NOP);
            end
`endif
        end else begin
            if (valid_q && !stall) begin
                valid_d = 1'b0;
            end
            unique case (state_q)
                S_REQ: begin
                    if (accept) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        if (kill_q) begin
                            kill_d = 1'b0;
                        end else if (slot_free) begin
                            pc_d      = req_pc_q;
                            inst_d    = imem_rdata;
                            inst_en_d = predecode(imem_rdata);
                            valid_d   = 1'b1;
                        end else begin
                            skid_pc_d   = req_pc_q;
                            skid_inst_d = imem_rdata;
                            state_d     = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (!stall) begin
                        pc_d      = skid_pc_q;
                        inst_d    = skid_inst_q;
                        inst_en_d = predecode(skid_inst_q);
                        valid_d   = 1'b1;
                        state_d   = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            kill_q      <= 1'b0;
            pc_q        <= RESET_PC;
            inst_q      <= NOP;
            inst_en_q   <= 32'hFFFF_FFEF;
            valid_q     <= 1'b0;
            skid_pc_q   <= 32'h0000_0000;
            skid_inst_q <= 32'h0000_0000;
`ifdef IF_MISALIGN_EXC_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            inst_en_q   <= inst_en_d;
            valid_q     <= valid_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
`ifdef IF_MISALIGN_EXC_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the architectural fetch PC and runs a one-outstanding request/response handshake with instruction memory.
- Registers the fetched word, its PC and a predecoded one-hot opcode vector (inst_enable, active low) for decode to consume.
- Accepts redirects (branch/jump/trap/mret targets) and holds its output under downstream stall.

Parameters:
RESET_PC, 32'h0000_0000, fetch address issued first after reset.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active high
imem_req  output  1  address-phase request valid
imem_addr  output  32  fetch address, word aligned
imem_ack  input  1  memory accepts address when imem_req&imem_ack at a rising edge
imem_rvalid  input  1  read data valid; at least 1 cycle after accept
imem_rdata  input  32  instruction word, sampled when imem_rvalid=1
stall  input  1  downstream cannot take the held instruction
redirect  input  1  flush, then restart fetch at redirect_pc
redirect_pc  input  32  new fetch target
pc  output  32  PC of held instruction
inst  output  32  held instruction word
inst_enable  output  32  active-low one-hot of inst[6:2]; all ones if inst[1:0]!=2'b11
inst_valid  output  1  held instruction valid

Behaviour:
- Reset (rst=1 at edge):
  - state=REQ, fetch_pc=RESET_PC, kill=0, inst_valid=0.
  - pc=RESET_PC, inst=32'h0000_0013, inst_enable=32'hFFFF_FFEF.
- Reset overrides everything, including mid-WAIT.
  - Instruction memory shares rst, so no pre-reset response can arrive afterwards.
- States:
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On accept: go to WAIT, fetch_pc+=4 (32-bit wrap, FFFF_FFFC -> 0000_0000).
    - Unaccepted requests may change address or drop; no transaction exists until accept.
  - WAIT: imem_req=0. On imem_rvalid:
    - If kill=1: discard the data, kill=0, go to REQ.
    - Else if the output slot is free (inst_valid=0 or stall=0): load pc=address of that fetch, inst=imem_rdata, recompute inst_enable, inst_valid=1, go to REQ.
    - Else: capture into a one-entry skid register, go to HOLD.
  - HOLD: imem_req=0. When stall=0, the skid entry moves to the output registers, then go to REQ.
- Output consumption: when inst_valid=1 and stall=0 with no new load, inst_valid=0 next edge.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency (REQ accept, WAIT response).
- Redirect (highest priority below rst):
  - Sets fetch_pc=redirect_pc and inst_valid=0 next edge, and clears the skid entry.
  - Overrides stall.
  - In REQ: next cycle imem_addr=redirect_pc; the current-edge accept is treated as killed (kill=1, go to WAIT).
  - In WAIT without rvalid: kill=1, stay in WAIT.
  - In WAIT with rvalid on the same edge: discard the data, go to REQ.
  - In HOLD: go to REQ.
  - Back-to-back redirects: the last one wins.
- inst_enable: bit k = 0 iff inst[6:2]==k and inst[1:0]==2'b11.
  - Key bits: load 0, imm 4, auipc 5, store 8, reg 12, lui 13, branch 24, jalr 25, jal 27, system 28.
- All outputs are registered except imem_req and imem_addr, which are decoded from state and fetch_pc.

Optional Feature:
- Macro IF_MISALIGN_EXC_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 does not issue a fetch. Next edge: inst_valid=1, pc=redirect_pc, inst=32'h0000_0013, fetch_misalign=1; state stays REQ with the request gated off.
  - Fetch resumes only after a following aligned redirect, which clears fetch_misalign.
- Undefined: no port; redirect_pc[1:0] is ignored and forced to 00 on imem_addr.

Test Plan:
- Reset release, memory acks immediately with 1-cycle rvalid, rdata=0x00500093 -> first imem_addr=0x00000000; inst_valid=1 with pc=0, inst_enable=0xFFFFFFEF; second imem_addr=0x00000004.
- stall=1 held 5 cycles with an instruction held -> pc/inst stable; the next response is parked in HOLD; no new imem_req; on stall=0 the parked word appears next edge, then the request for pc+8 issues.
- redirect=1, redirect_pc=0x00000100 while in WAIT, stale rvalid 2 cycles later -> stale data dropped; inst_valid=0; next imem_addr=0x100.
- redirect coincident with imem_rvalid and stall=1 -> response discarded, inst_valid=0 next edge, fetch at the new target.
- rdata with opcode 0x6F (jal), 0x73 (system), and inst[1:0]=2'b01 -> inst_enable=0xF7FFFFFF, 0xEFFFFFFF, 0xFFFFFFFF.
- rst asserted mid-WAIT -> next edge: state REQ at RESET_PC, inst_valid=0; fetch_pc wraps from 0xFFFFFFFC to 0x0 on a separate run.
